// File: rtl/counter_spi_if.sv
// counter_spi_if: groups the counter_top scan bus and the SPI control pins.
//   countout  count bus from counter_top
//   oe, sel   output enable and channel select to counter_top
//   ss_n, sck SPI slave select and clock from the master
interface counter_spi_if;
    logic [7:0] countout;
    logic       oe;
    logic [1:0] sel;
    logic       ss_n;
    logic       sck;
    modport slave  (input  countout, ss_n, sck, output oe, sel);
    modport master (output countout, ss_n, sck, input  oe, sel);
endinterface

// File: rtl/counter_spi.sv
// counter_spi: snapshots nc encoder counts on SPI frame start and shifts them plus an XOR checksum out as an SPI mode-0 slave.
//   clk   system clock, same domain as counter_top
//   rst   asynchronous active-low reset
//   bus   counter_top scan bus (countout/oe/sel) and SPI inputs (ss_n/sck)
//   miso  SPI data out, high-Z while the synchronised ss_n is high
module counter_spi #(
    parameter int nc = 4
) (
    input  logic         clk,
    input  logic         rst,
    counter_spi_if.slave bus,
    output wire          miso
);
    typedef enum logic [1:0] {IDLE, DRIVE, CAPT, LOAD} state_t;
    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d, sel_q, sel_d;
    logic       oe_q, oe_d;
    logic [2:0] ss_sync_q, ss_sync_d, sck_sync_q, sck_sync_d;
    logic [7:0] snap_q [nc];
    logic [7:0] snap_d [nc];
    logic [7:0] chk_q, chk_d, sh_q, sh_d, nxt_byte, xr;
    logic [2:0] bit_q, bit_d, byte_q, byte_d, byte_nx;
    logic       ready_q, ready_d;
    logic       ss_fall, ss_rise, sck_fall;

    // Two synchroniser flops, the third only for edge detection.
    assign ss_sync_d  = {ss_sync_q[1:0], bus.ss_n};
    assign sck_sync_d = {sck_sync_q[1:0], bus.sck};
    assign ss_fall    = ss_sync_q[2] & ~ss_sync_q[1];
    assign ss_rise    = ~ss_sync_q[2] & ss_sync_q[1];
    assign sck_fall   = sck_sync_q[2] & ~sck_sync_q[1];
    assign bus.oe     = oe_q;
    assign bus.sel    = sel_q;
    // Drive 0 while the frame is open but the snapshot is not yet loaded.
    assign miso       = ss_sync_q[1] ? 1'bz : (ready_q ? sh_q[7] : 1'b0);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE:    if (ss_fall) begin
                         state_d = DRIVE;
                         idx_d   = 2'd0;
                     end
            DRIVE:   state_d = CAPT;
            CAPT:    if (idx_q == 2'(nc - 1)) state_d = LOAD;
                     else begin
                         state_d = DRIVE;
                         idx_d   = idx_q + 2'd1;
                     end
            default: state_d = IDLE;
        endcase
        // oe/sel are registered from the next state so counter_top sees them a cycle ahead of CAPT.
        oe_d  = (state_d == DRIVE) || (state_d == CAPT);
        sel_d = oe_d ? idx_d : sel_q;
    end

    always_comb begin
        snap_d = snap_q;
        if (state_q == CAPT) snap_d[idx_q] = bus.countout;
        xr = 8'h00;
        for (int k = 0; k < nc; k++) xr = xr ^ snap_q[k];
        chk_d = (state_q == LOAD) ? xr : chk_q;
    end

    always_comb begin
        byte_nx  = (byte_q == 3'(nc + 1)) ? byte_q : byte_q + 3'd1;
        nxt_byte = (byte_nx < 3'(nc)) ? snap_q[byte_nx[1:0]] : ((byte_nx == 3'(nc)) ? chk_q : 8'h00);
        sh_d     = sh_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        ready_d  = ready_q;
        if (state_q == LOAD) begin
            sh_d    = snap_q[0];
            bit_d   = 3'd0;
            byte_d  = 3'd0;
            ready_d = 1'b1;
        end else if (ready_q && sck_fall) begin
            bit_d = bit_q + 3'd1;
            sh_d  = {sh_q[6:0], 1'b0};
            if (bit_q == 3'd7) begin
                byte_d = byte_nx;
                sh_d   = nxt_byte;
            end
        end
        if (ss_rise) begin
            ready_d = 1'b0;
            bit_d   = 3'd0;
            byte_d  = 3'd0;
        end
        if (ss_fall && state_q == IDLE) ready_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            sel_q      <= 2'd0;
            oe_q       <= 1'b0;
            ss_sync_q  <= 3'b111;
            sck_sync_q <= 3'b000;
            for (int k = 0; k < nc; k++) snap_q[k] <= 8'h00;
            chk_q      <= 8'h00;
            sh_q       <= 8'h00;
            bit_q      <= 3'd0;
            byte_q     <= 3'd0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sel_q      <= sel_d;
            oe_q       <= oe_d;
            ss_sync_q  <= ss_sync_d;
            sck_sync_q <= sck_sync_d;
            snap_q     <= snap_d;
            chk_q      <= chk_d;
            sh_q       <= sh_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            ready_q    <= ready_d;
        end
    end
endmodule

// File: tb/tb_counter_spi.sv
// tb_counter_spi: directed frames against a counter_top count-bus model, checking scan timing and the MISO stream.
module tb_counter_spi;
    logic clk = 1'b0;
    logic rst = 1'b0;
    wire  miso;
    logic [7:0] vals [4];
    logic [7:0] exp_b [7];
    int n_tot = 0;
    int n_bad = 0;

    counter_spi_if bus();
    counter_spi #(.nc(4)) dut (.clk(clk), .rst(rst), .bus(bus), .miso(miso));
    // An undriven miso reads as 1, distinguishing high-Z from the driven 0 of a busy frame.
    pullup (miso);

    always #5 clk = ~clk;

    // counter_top model: countout follows the registered oe/sel one cycle later.
    always @(posedge clk) bus.countout <= bus.oe ? vals[bus.sel] : 8'hee;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic sck_bit(output logic b);
        b = miso;
        bus.sck = 1'b1;
        repeat (5) @(negedge clk);
        bus.sck = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic sck_byte(output logic [7:0] b);
        logic v;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            sck_bit(v);
            b = {b[6:0], v};
        end
    endtask

    task automatic open_frame();
        @(negedge clk);
        bus.ss_n = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    task automatic close_frame(input string tag);
        bus.ss_n = 1'b1;
        repeat (5) @(negedge clk);
        check({tag, "_miso_z"}, 16'(miso), 16'h1);
    endtask

    task automatic read_bytes(input string tag, input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            sck_byte(b);
            check($sformatf("%s_b%0d", tag, i), 16'(b), 16'(exp_b[i]));
        end
    endtask

    initial begin
        logic [15:0] seq;
        int oe_n;
        logic [7:0] b;
        logic v;
        bus.ss_n = 1'b1;
        bus.sck  = 1'b0;
        vals = '{8'h12, 8'h34, 8'h56, 8'h78};
        repeat (3) @(negedge clk);
        check("rst_oe", 16'(bus.oe), 16'h0);
        check("rst_sel", 16'(bus.sel), 16'h0);
        check("rst_miso_z", 16'(miso), 16'h1);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_oe", 16'(bus.oe), 16'h0);

        // Basic frame: scan timing, then 7 bytes to show the saturating zero tail.
        @(negedge clk);
        bus.ss_n = 1'b0;
        seq = 16'h0;
        oe_n = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (bus.oe) begin
                oe_n++;
                seq = {seq[13:0], bus.sel};
            end
            if (k == 2) check("busy_miso0", 16'(miso), 16'h0);
        end
        check("oe_cycles", 16'(oe_n), 16'd8);
        check("sel_seq", seq, 16'h05af);
        check("sel_hold", 16'(bus.sel), 16'h3);
        exp_b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h08, 8'h00, 8'h00};
        read_bytes("basic", 7);
        close_frame("basic");

        // Coherence: counts move 20 cycles into the frame; this frame keeps the old ones.
        @(negedge clk);
        bus.ss_n = 1'b0;
        repeat (20) @(negedge clk);
        vals = '{8'ha5, 8'h0f, 8'hf0, 8'h3c};
        read_bytes("coh_old", 5);
        close_frame("coh_old");
        open_frame();
        exp_b = '{8'ha5, 8'h0f, 8'hf0, 8'h3c, 8'h66, 8'h00, 8'h00};
        read_bytes("coh_new", 5);
        close_frame("coh_new");

        // Abort after 11 bits; the next frame restarts at snap[0].
        open_frame();
        sck_byte(b);
        check("abort_b0", 16'(b), 16'ha5);
        for (int i = 0; i < 3; i++) sck_bit(v);
        bus.ss_n = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_miso_z", 16'(miso), 16'h1);
        vals = '{8'h81, 8'h42, 8'h24, 8'h18};
        open_frame();
        exp_b = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hff, 8'h00, 8'h00};
        read_bytes("restart", 6);
        close_frame("restart");

        // Reset during CAPT(2): oe/sel drop without waiting for a clock.
        @(negedge clk);
        bus.ss_n = 1'b0;
        repeat (8) @(negedge clk);
        check("capt2_oe", 16'(bus.oe), 16'h1);
        check("capt2_sel", 16'(bus.sel), 16'h2);
        rst = 1'b0;
        bus.ss_n = 1'b1;
        #1;
        check("mid_rst_oe", 16'(bus.oe), 16'h0);
        check("mid_rst_sel", 16'(bus.sel), 16'h0);
        check("mid_rst_miso_z", 16'(miso), 16'h1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        vals = '{8'hde, 8'had, 8'hbe, 8'hef};
        open_frame();
        exp_b = '{8'hde, 8'had, 8'hbe, 8'hef, 8'h22, 8'h00, 8'h00};
        read_bytes("post_rst", 6);
        close_frame("post_rst");

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/counter_spi.md
# counter_spi

Downstream reader for `counter_top`. On each SPI frame start it drives `oe`/`sel` to scan all encoder channels and latches their 8-bit counts into a coherent snapshot. It then shifts the snapshot, followed by an XOR checksum, to the robot microcontroller through an SPI mode‑0 slave. It sits between `counter_top` and the board SPI pins, in the same clock domain as `counter_top`.

## Interface
Parameters:
- `nc`, 4: number of encoder channels scanned; `sel` width is fixed at 2, so `nc` ≤ 4.

Ports:
- `clk`  in  1  system clock, same as `counter_top`.
- `rst`  in  1  reset, asynchronous and active-low.
- `countout`  in  8  count bus from `counter_top`.
- `oe`  out  1  output enable to `counter_top`.
- `sel`  out  2  channel select to `counter_top`.
- `ss_n`  in  1  SPI slave select, active-low, asynchronous to `clk`.
- `sck`  in  1  SPI clock, asynchronous to `clk`.
- `miso`  out  1  SPI data out; high-Z while `ss_n` is high.

## Operation
- **Synchronisers.** `ss_n` and `sck` each pass through a 2-flop synchroniser, then a third flop for edge detection. All logic uses the synchronised versions.
- **Snapshot FSM states:** IDLE, DRIVE(i), CAPT(i), LOAD.
  - IDLE: `oe`=0, `sel` holds its last value. On a synchronised `ss_n` falling edge, go to DRIVE(0).
  - DRIVE(i): registered `oe`=1, `sel`=i. Next state is CAPT(i).
  - CAPT(i): `oe`=1, `sel`=i. On the closing edge, capture `countout` into `snap[i]`. Next state is DRIVE(i+1), or LOAD after i=nc‑1.
  - LOAD: `oe`=0. Compute `chk` = XOR of `snap[0..nc-1]`, load the shift register with `snap[0]`, clear the bit and byte counters, set `ready`=1. Next state is IDLE.
  - A snapshot always runs to completion once started. `ss_n` edges during the scan are ignored by the FSM.
- **Frame layout:** bytes `snap[0]` … `snap[nc-1]`, then `chk`, then 0x00 for every further byte. Each byte is sent MSB first.
- **SPI mode 0:**
  - `miso` presents the shift-register MSB.
  - On a synchronised `sck` falling edge, shift left one bit and increment the bit counter.
  - After the 8th fall, load the next frame byte. The byte counter saturates at nc+1, so there is no wrap.
- **MOSI:** not connected. Commands are out of scope.
- **Frame abort:** a synchronised `ss_n` rising edge mid-frame clears `ready`, the bit counter and the byte counter, and puts `miso` in high-Z. The next frame rescans all channels.
- **`ready` flag:** while `ss_n` is low and `ready`=0 (scan still in progress), `miso` drives 0.
- **Reset values:** `oe`=0, `sel`=0, `miso` high-Z, `snap[*]`=0, `chk`=0, FSM in IDLE, `ready`=0, counters 0, synchroniser flops 1 for `ss_n` and 0 for `sck`.
- **Reset mid-scan:** returns everything to the reset values immediately.

## Timing
- **Synchroniser latency:** a pin edge is seen as a detected edge 3 `clk` rising edges later.
- **Scan length:** 2·nc+1 cycles from DRIVE(0) to LOAD inclusive, which is 9 cycles for nc=4.
- **`counter_top` contract:** `countout` is valid on the rising edge one cycle after `oe`/`sel` are registered. CAPT samples exactly at that edge.
- **First data bit:** `snap[0]` MSB appears on `miso` no later than 13 `clk` cycles after `ss_n` falls at the pin.
- **Master requirements:**
  - ≥16 `clk` from `ss_n` fall to the first `sck` rise.
  - `sck` high and low each ≥4 `clk`.
  - `ss_n` high ≥4 `clk` between frames.
- **Within a frame:** `miso` updates 3–4 `clk` after each `sck` fall pin edge, well before the next rise.
- **Coherence:** all nc counts come from consecutive `clk` cycles. Counter movement during the SPI transfer never alters an already-started frame.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles, release → `oe`=0, `sel`=0, `miso`=z, and with no frame open `countout` is never sampled.
- **Basic frame:** a `countout` model returns 0x12, 0x34, 0x56, 0x78 for `sel`=0..3; drop `ss_n`, wait 16 clk, clock 48 bits (sck period 10 clk).
  - Scan: `oe` is high for exactly 8 cycles and `sel` steps 0,0,1,1,2,2,3,3.
  - MISO stream: 0x12 0x34 0x56 0x78 0x08 (checksum) 0x00.
- **Coherence:** change the model values 20 cycles after `ss_n` falls → frame still carries the first sampled values. The next frame carries the new ones.
- **Abort:** raise `ss_n` after 11 bits, wait 4 clk, start a new frame → `miso`=z while high, and the new frame restarts at a fresh `snap[0]` MSB.
- **Reset mid-scan:** assert `rst` during CAPT(2) → `oe`=0 and `sel`=0 at once. After release, a fresh frame returns correct values.
- **Tie-in with `counter_top`:** drive random quadrature on all 4 channels and read 200 frames → each byte matches the channel count at scan time, within ±1 on filtered channels.
